// File: rtl/chat_session_ctrl.sv
// Messenger session controller: user login with per-user password, retry lockout,
// and a scrollable circular history of received messages feeding the LCD muxes.
module chat_session_ctrl #(
    parameter int NUM_USERS   = 2,
    parameter int MSG_BYTES   = 16,
    parameter int HIST_DEPTH  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 50000000,
    localparam int UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
    localparam int PW = $clog2(HIST_DEPTH),
    localparam int HW = $clog2(HIST_DEPTH + 1),
    localparam int MW = 8 * MSG_BYTES
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   key_valid,
    input  logic [7:0]             key_ascii,
    input  logic                   rx_valid,
    input  logic [MW-1:0]          rx_msg,
    input  logic                   logout,
    input  logic [8*NUM_USERS-1:0] pw_table,
    output logic [2:0]             state,
    output logic [UW-1:0]          user_idx,
    output logic                   lcd_clear,
    output logic                   lockout,
    output logic [MW-1:0]          view_msg,
    output logic [HW-1:0]          hist_count
);

    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int CW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [7:0] KEY_FIRST = 8'h31;
    localparam logic [7:0] KEY_LAST  = 8'(8'h30 + NUM_USERS);
    localparam logic [7:0] KEY_OLDER = 8'h5B;
    localparam logic [7:0] KEY_NEWER = 8'h5D;

    typedef enum logic [2:0] {
        S_LOGIN     = 3'd0,
        S_PASSWORD  = 3'd1,
        S_SENDING   = 3'd2,
        S_RECEIVING = 3'd3,
        S_LOCKOUT   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [UW-1:0] user_q, user_d;
    logic [CW-1:0] tries_q, tries_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] view_off_q, view_off_d;
    logic [HW-1:0] count_q, count_d;
    logic          clear_q, clear_d;
    logic          lock_q;
    logic          push;
    logic          scroll;
    logic [PW-1:0] rd_idx;
    logic [MW-1:0] hist_q [HIST_DEPTH];

    // Priority: logout, then the running lockout timer (keys and rx are dead there),
    // then a history push, then the key decode. A push swallows a same-cycle key.
    always_comb begin
        state_d    = state_q;
        user_d     = user_q;
        tries_d    = tries_q;
        timer_d    = timer_q;
        wr_ptr_d   = wr_ptr_q;
        view_off_d = view_off_q;
        count_d    = count_q;
        push       = 1'b0;
        scroll     = 1'b0;
        if (logout) begin
            state_d    = S_LOGIN;
            user_d     = '0;
            tries_d    = '0;
            timer_d    = '0;
            view_off_d = '0;
            count_d    = '0;
        end else if (state_q == S_LOCKOUT) begin
            if (timer_q == '0) begin
                state_d = S_LOGIN;
                user_d  = '0;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end else if (rx_valid && (state_q == S_SENDING || state_q == S_RECEIVING)) begin
            push       = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            view_off_d = '0;
            state_d    = S_RECEIVING;
            if (count_q != HW'(HIST_DEPTH)) begin
                count_d = count_q + HW'(1);
            end
        end else if (key_valid) begin
            case (state_q)
                S_LOGIN: begin
                    if (key_ascii >= KEY_FIRST && key_ascii <= KEY_LAST) begin
                        user_d  = UW'(key_ascii - KEY_FIRST);
                        state_d = S_PASSWORD;
                    end
                end
                S_PASSWORD: begin
                    if (key_ascii == pw_table[8*user_q +: 8]) begin
                        state_d = S_SENDING;
                        tries_d = '0;
                    end else if (int'(tries_q) + 1 < MAX_TRIES) begin
                        tries_d = tries_q + CW'(1);
                    end else begin
                        state_d = S_LOCKOUT;
                        timer_d = TW'(LOCK_CYCLES - 1);
                        tries_d = '0;
                    end
                end
                S_RECEIVING: begin
                    if (key_ascii == KEY_OLDER) begin
                        scroll = 1'b1;
                        if (HW'(view_off_q) + HW'(1) < count_q) begin
                            view_off_d = view_off_q + PW'(1);
                        end
                    end else if (key_ascii == KEY_NEWER) begin
                        scroll = 1'b1;
                        if (view_off_q != '0) begin
                            view_off_d = view_off_q - PW'(1);
                        end
                    end else begin
                        state_d    = S_SENDING;
                        view_off_d = '0;
                    end
                end
                default: ;
            endcase
        end
        clear_d = (state_d != state_q) || scroll;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_LOGIN;
            user_q     <= '0;
            tries_q    <= '0;
            timer_q    <= '0;
            wr_ptr_q   <= '0;
            view_off_q <= '0;
            count_q    <= '0;
            clear_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            user_q     <= user_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            wr_ptr_q   <= wr_ptr_d;
            view_off_q <= view_off_d;
            count_q    <= count_d;
            clear_q    <= clear_d;
            lock_q     <= (state_d == S_LOCKOUT);
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            hist_q[wr_ptr_q] <= rx_msg;
        end
    end

    assign rd_idx     = wr_ptr_q - PW'(1) - view_off_q;
    assign view_msg   = (count_q == '0) ? {MSG_BYTES{8'h20}} : hist_q[rd_idx];
    assign state      = state_q;
    assign user_idx   = user_q;
    assign lcd_clear  = clear_q;
    assign lockout    = lock_q;
    assign hist_count = count_q;

endmodule

// File: tb/tb_chat_session_ctrl.sv
// Directed and randomized stimulus for chat_session_ctrl, checked every cycle
// against a queue-based model of the session rules.
module tb_chat_session_ctrl;

  localparam int NU = 2;
  localparam int MB = 4;
  localparam int HD = 4;
  localparam int MT = 3;
  localparam int LC = 10;
  localparam int MW = 8 * MB;

  // clock / reset
  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          key_valid = 1'b0;
  logic [7:0]    key_ascii = 8'h00;
  logic          rx_valid = 1'b0;
  logic [MW-1:0] rx_msg = '0;
  logic          logout = 1'b0;
  logic [15:0]   pw_table = {8'h31, 8'h30};
  logic [2:0]    state;
  logic [0:0]    user_idx;
  logic          lcd_clear;
  logic          lockout;
  logic [MW-1:0] view_msg;
  logic [2:0]    hist_count;

  always #5 clock = ~clock;

  chat_session_ctrl #(
    .NUM_USERS(NU), .MSG_BYTES(MB), .HIST_DEPTH(HD), .MAX_TRIES(MT), .LOCK_CYCLES(LC)
  ) dut (
    .clock(clock), .resetn(resetn), .key_valid(key_valid), .key_ascii(key_ascii),
    .rx_valid(rx_valid), .rx_msg(rx_msg), .logout(logout), .pw_table(pw_table),
    .state(state), .user_idx(user_idx), .lcd_clear(lcd_clear), .lockout(lockout),
    .view_msg(view_msg), .hist_count(hist_count)
  );

  // reference model: history kept as a queue, newest at the back
  int            n_checks = 0;
  int            n_fail = 0;
  int            m_state, m_user, m_tries, m_lock_left, m_off;
  bit            m_clear;
  logic [MW-1:0] exp_q[$];
  logic [7:0]    pw_of[NU] = '{8'h30, 8'h31};
  logic [7:0]    key_pool[8] = '{8'h31, 8'h32, 8'h33, 8'h30, 8'h31, 8'h5B, 8'h5D, 8'h61};
  logic [MW-1:0] msgs[5];

  task automatic model_reset();
    m_state = 0; m_user = 0; m_tries = 0; m_lock_left = 0; m_off = 0; m_clear = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit lo, input bit rv, input bit kv,
                            input logic [7:0] ka, input logic [MW-1:0] msg);
    int  prev;
    bit  scroll;
    prev = m_state;
    scroll = 0;
    if (lo) begin
      m_state = 0; m_user = 0; m_tries = 0; m_off = 0;
      exp_q.delete();
    end else if (m_state == 4) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_state = 0; m_user = 0;
      end
    end else if (rv && (m_state == 2 || m_state == 3)) begin
      exp_q.push_back(msg);
      if (exp_q.size() > HD) void'(exp_q.pop_front());
      m_off = 0;
      m_state = 3;
    end else if (kv) begin
      case (m_state)
        0: if (int'(ka) >= 'h31 && int'(ka) <= 'h30 + NU) begin
             m_user = int'(ka) - 'h31;
             m_state = 1;
           end
        1: if (ka == pw_of[m_user]) begin
             m_state = 2; m_tries = 0;
           end else begin
             m_tries++;
             if (m_tries == MT) begin
               m_state = 4; m_lock_left = LC; m_tries = 0;
             end
           end
        3: if (ka == 8'h5B) begin
             scroll = 1;
             if (m_off < exp_q.size() - 1) m_off++;
           end else if (ka == 8'h5D) begin
             scroll = 1;
             if (m_off > 0) m_off--;
           end else begin
             m_state = 2; m_off = 0;
           end
        default: ;
      endcase
    end
    m_clear = (m_state != prev) || scroll;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [MW-1:0] ev;
    ev = (exp_q.size() == 0) ? {MB{8'h20}} : exp_q[exp_q.size() - 1 - m_off];
    chk("state", 64'(state), 64'(m_state));
    chk("user_idx", 64'(user_idx), 64'(m_user));
    chk("lcd_clear", 64'(lcd_clear), 64'(m_clear));
    chk("lockout", 64'(lockout), 64'(m_state == 4));
    chk("hist_count", 64'(hist_count), 64'(exp_q.size()));
    chk("view_msg", 64'(view_msg), 64'(ev));
  endtask

  // driver tasks
  task automatic step(input bit lo, input bit rv, input bit kv,
                      input logic [7:0] ka, input logic [MW-1:0] msg);
    logout = lo; rx_valid = rv; key_valid = kv; key_ascii = ka; rx_msg = msg;
    @(posedge clock);
    model_step(lo, rv, kv, ka, msg);
    #1;
    logout = 0; rx_valid = 0; key_valid = 0;
    check_outputs();
  endtask

  task automatic key(input logic [7:0] k);
    step(0, 0, 1, k, '0);
  endtask

  task automatic push(input logic [MW-1:0] m);
    step(0, 1, 0, 8'h00, m);
  endtask

  task automatic do_reset();
    resetn = 0;
    #2;
    model_reset();
    check_outputs();
    @(posedge clock);
    #1;
    resetn = 1;
  endtask

  initial begin
    int r;
    #1;
    do_reset();

    // login as user 1 (password '1')
    key(8'h32);
    key(8'h31);
    step(0, 0, 0, 8'h00, '0);
    step(1, 0, 0, 8'h00, '0);

    // three wrong passwords for user 0, then keys during lockout
    key(8'h31);
    key(8'h78); key(8'h79); key(8'h7A);
    for (int i = 0; i < 12; i++) key(8'h30);
    step(1, 0, 0, 8'h00, '0);
    step(1, 0, 0, 8'h00, '0);

    // fill and wrap history, then scroll
    key(8'h32); key(8'h31);
    for (int i = 0; i < 5; i++) begin
      msgs[i] = $urandom;
      push(msgs[i]);
    end
    chk("wrap_newest", 64'(view_msg), 64'(msgs[4]));
    for (int i = 0; i < 4; i++) key(8'h5B);
    chk("scroll_oldest", 64'(view_msg), 64'(msgs[1]));
    key(8'h5D);
    chk("scroll_back", 64'(view_msg), 64'(msgs[2]));

    // push and key together: key is discarded
    step(0, 1, 1, 8'h61, $urandom);

    // logout beats a same-cycle push
    step(1, 0, 0, 8'h00, '0);
    key(8'h32); key(8'h31);
    push($urandom); push($urandom);
    step(1, 1, 0, 8'h00, $urandom);
    chk("logout_clears_view", 64'(view_msg), 64'({MB{8'h20}}));

    // rx in LOGIN is dropped; reset clears a partial try count
    push($urandom);
    key(8'h31); key(8'h78); key(8'h79);
    do_reset();
    key(8'h31); key(8'h78);
    step(0, 0, 0, 8'h00, '0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (n % 250 == 249) do_reset();
      else if (r < 3) step(1, 0, 0, 8'h00, '0);
      else if (r < 28) push($urandom);
      else if (r < 75) key(key_pool[$urandom_range(0, 7)]);
      else step(0, 0, 0, 8'h00, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
